spi_single_clk_periph: RTL and testbench

- SPI mode-0 (CPOL=0, CPHA=0) slave fully oversampled in the single sys_clk domain; no logic clocked by SCK.
- Pads are synchronised and edge-detected. The first byte of each CS-low frame is an address; all following bytes are data.
- Provides byte-valid strobes and a data-request/data-written handshake for MISO. Sits between the board SPI pads and the register/bus logic.

---
 rtl/spi_single_clk_pkg.sv | 18 +
 rtl/spi_pad_sync.sv | 31 +++
 rtl/spi_single_clk_periph.sv | 166 ++++++++++++++++
 tb/tb_spi_single_clk_periph.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/spi_single_clk_pkg.sv
// Shared constants and FSM encoding for the sys_clk-oversampled SPI mode-0 peripheral.
package spi_single_clk_pkg;

    localparam int SPI_BYTE_W = 8;
    localparam int RW_BIT     = SPI_BYTE_W - 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } spi_state_t;

    // Read/write flag position for an arbitrary word width.
    function automatic int rw_bit(input int byte_w);
        return byte_w - 1;
    endfunction

endpackage

// File: rtl/spi_pad_sync.sv
// Two-flop synchroniser for an asynchronous pad plus a third history stage for edge detection.
module spi_pad_sync (
    input  logic clk,
    input  logic rst,
    input  logic pad,
    output logic level,
    output logic rise,
    output logic fall
);

    logic meta_p0;
    logic sync_p1;
    logic hist_p2;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            hist_p2 <= 1'b0;
        end else begin
            meta_p0 <= pad;
            sync_p1 <= meta_p0;
            hist_p2 <= sync_p1;
        end
    end

    assign level = sync_p1;
    assign rise  = sync_p1 & ~hist_p2;
    assign fall  = ~sync_p1 & hist_p2;

endmodule

// File: rtl/spi_single_clk_periph.sv
// SPI mode-0 slave oversampled entirely in sys_clk: first byte of a frame is the address, the rest data.
// Optional SPI_ADDR_AUTOINC_EN: every data byte after the first bumps spi_address_rx by one.
module spi_single_clk_periph
    import spi_single_clk_pkg::*;
#(
    parameter int BYTE_W = SPI_BYTE_W
) (
    input  logic              sys_clk,
    input  logic              rst,
    input  logic              csn_pad,
    input  logic              sck_pad,
    input  logic              mosi_pad,
    output logic              miso_pad,
    input  logic              spi_data_written,
    input  logic [BYTE_W-1:0] spi_data_to_send,
    output logic [BYTE_W-1:0] spi_address_rx,
    output logic [BYTE_W-1:0] spi_data_byte_rx,
    output logic              spi_address_rx_valid,
    output logic              spi_data_byte_rx_valid,
    output logic              spi_dreq,
    output logic              valid_read
);

    localparam int                CNT_W    = $clog2(BYTE_W);
    localparam int                RWB      = rw_bit(BYTE_W);
    localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(BYTE_W - 1);

    logic csn_level, csn_rise, csn_fall;
    logic sck_level, sck_rise, sck_fall;
    logic mosi_level, mosi_rise, mosi_fall;
    logic unused_edges;

    spi_pad_sync u_csn_sync (
        .clk   (sys_clk),
        .rst   (rst),
        .pad   (csn_pad),
        .level (csn_level),
        .rise  (csn_rise),
        .fall  (csn_fall)
    );

    spi_pad_sync u_sck_sync (
        .clk   (sys_clk),
        .rst   (rst),
        .pad   (sck_pad),
        .level (sck_level),
        .rise  (sck_rise),
        .fall  (sck_fall)
    );

    spi_pad_sync u_mosi_sync (
        .clk   (sys_clk),
        .rst   (rst),
        .pad   (mosi_pad),
        .level (mosi_level),
        .rise  (mosi_rise),
        .fall  (mosi_fall)
    );

    assign unused_edges = ^{sck_level, mosi_rise, mosi_fall};

    spi_state_t        state;
    logic [CNT_W-1:0]  bit_cnt;
    logic [BYTE_W-1:0] rx_shreg;
    logic [BYTE_W-1:0] tx_shreg;
    logic [BYTE_W-1:0] tx_buf;
    logic              byte_done;
    logic              reload_pending;
`ifdef SPI_ADDR_AUTOINC_EN
    logic              first_data_seen;
`endif

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state                  <= ST_IDLE;
            bit_cnt                <= '0;
            rx_shreg               <= '0;
            tx_shreg               <= '0;
            tx_buf                 <= '0;
            byte_done              <= 1'b0;
            reload_pending         <= 1'b0;
            spi_address_rx         <= '0;
            spi_data_byte_rx       <= '0;
            spi_address_rx_valid   <= 1'b0;
            spi_data_byte_rx_valid <= 1'b0;
            spi_dreq               <= 1'b0;
            valid_read             <= 1'b0;
`ifdef SPI_ADDR_AUTOINC_EN
            first_data_seen        <= 1'b0;
`endif
        end else begin
            spi_address_rx_valid   <= 1'b0;
            spi_data_byte_rx_valid <= 1'b0;
            spi_dreq               <= 1'b0;

            if (spi_data_written) begin
                tx_buf <= spi_data_to_send;
            end

            // Frame boundaries win over any SCK activity in the same cycle.
            if (csn_rise) begin
                state          <= ST_IDLE;
                bit_cnt        <= '0;
                byte_done      <= 1'b0;
                reload_pending <= 1'b0;
                valid_read     <= 1'b0;
            end else if (csn_fall) begin
                state          <= ST_ADDR;
                bit_cnt        <= '0;
                byte_done      <= 1'b0;
                reload_pending <= 1'b0;
                tx_shreg       <= tx_buf;
                spi_dreq       <= 1'b1;
`ifdef SPI_ADDR_AUTOINC_EN
                first_data_seen <= 1'b0;
`endif
            end else if (state != ST_IDLE) begin
                byte_done <= 1'b0;

                if (sck_rise) begin
                    rx_shreg <= {rx_shreg[BYTE_W-2:0], mosi_level};
                    if (bit_cnt == LAST_BIT) begin
                        bit_cnt        <= '0;
                        byte_done      <= 1'b1;
                        reload_pending <= 1'b1;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end

                // The fall after a completed byte presents the next TX byte instead of shifting.
                if (sck_fall) begin
                    if (reload_pending) begin
                        tx_shreg       <= tx_buf;
                        reload_pending <= 1'b0;
                    end else begin
                        tx_shreg <= {tx_shreg[BYTE_W-2:0], 1'b0};
                    end
                end

                if (byte_done) begin
                    spi_dreq <= 1'b1;
                    if (state == ST_ADDR) begin
                        spi_address_rx       <= rx_shreg;
                        spi_address_rx_valid <= 1'b1;
                        valid_read           <= rx_shreg[RWB];
                        state                <= ST_DATA;
                    end else begin
                        spi_data_byte_rx       <= rx_shreg;
                        spi_data_byte_rx_valid <= 1'b1;
`ifdef SPI_ADDR_AUTOINC_EN
                        if (first_data_seen) begin
                            spi_address_rx       <= spi_address_rx + 1'b1;
                            spi_address_rx_valid <= 1'b1;
                        end
                        first_data_seen <= 1'b1;
`endif
                    end
                end
            end
        end
    end

    assign miso_pad = (state != ST_IDLE && !csn_level) ? tx_shreg[BYTE_W-1] : 1'b0;

endmodule

// File: tb/tb_spi_single_clk_periph.sv
// Bench for spi_single_clk_periph: table of SPI frames with a pulse scoreboard and a dreq responder.
`timescale 1ns/1ps
module tb_spi_single_clk_periph;

    logic       sys_clk = 1'b0;
    logic       rst = 1'b1;
    logic       csn_pad = 1'b1;
    logic       sck_pad = 1'b0;
    logic       mosi_pad = 1'b0;
    logic       miso_pad;
    logic       spi_data_written = 1'b0;
    logic [7:0] spi_data_to_send = 8'h00;
    logic [7:0] spi_address_rx;
    logic [7:0] spi_data_byte_rx;
    logic       spi_address_rx_valid;
    logic       spi_data_byte_rx_valid;
    logic       spi_dreq;
    logic       valid_read;

    spi_single_clk_periph #(.BYTE_W(8)) dut (
        .sys_clk                (sys_clk),
        .rst                    (rst),
        .csn_pad                (csn_pad),
        .sck_pad                (sck_pad),
        .mosi_pad               (mosi_pad),
        .miso_pad               (miso_pad),
        .spi_data_written       (spi_data_written),
        .spi_data_to_send       (spi_data_to_send),
        .spi_address_rx         (spi_address_rx),
        .spi_data_byte_rx       (spi_data_byte_rx),
        .spi_address_rx_valid   (spi_address_rx_valid),
        .spi_data_byte_rx_valid (spi_data_byte_rx_valid),
        .spi_dreq               (spi_dreq),
        .valid_read             (valid_read)
    );

    always #10 sys_clk = ~sys_clk;

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] d0;
        logic [7:0] d1;
        logic [7:0] d2;
        logic [2:0] ndata;
        logic [7:0] tx;
        logic       exp_vr;
        logic [3:0] exp_dreq;
        logic [7:0] exp_addr;
    } vec_t;

    vec_t       vecs [6];
    int         ntests = 0;
    int         nfail = 0;
    int         n_dreq = 0;
    int         n_avld = 0;
    int         n_dvld = 0;
    logic [7:0] resp_byte = 8'h00;
    logic [7:0] addr_q [$];
    logic       vr_q [$];
    logic [7:0] data_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic monitor();
        forever begin
            @(negedge sys_clk);
            if (!rst) begin
                if (spi_dreq) n_dreq++;
                if (spi_address_rx_valid) begin
                    n_avld++;
                    if (addr_q.size() == 0) begin
                        check("addr_pulse_unexpected", 32'(spi_address_rx), 32'hFFFF_FFFF);
                    end else begin
                        check("addr", 32'(spi_address_rx), 32'(addr_q.pop_front()));
                        check("valid_read_at_addr", 32'(valid_read), 32'(vr_q.pop_front()));
                    end
                end
                if (spi_data_byte_rx_valid) begin
                    n_dvld++;
                    if (data_q.size() == 0)
                        check("data_pulse_unexpected", 32'(spi_data_byte_rx), 32'hFFFF_FFFF);
                    else
                        check("data", 32'(spi_data_byte_rx), 32'(data_q.pop_front()));
                end
            end
        end
    endtask

    task automatic responder();
        forever begin
            @(negedge sys_clk);
            if (spi_dreq && !rst) begin
                spi_data_to_send = resp_byte;
                spi_data_written = 1'b1;
                @(negedge sys_clk);
                spi_data_written = 1'b0;
            end
        end
    endtask

    // One SCK period (240 ns): MOSI set, low half, master samples MISO, high half.
    task automatic sck_bit(input logic b, input logic exp_b, input bit chk);
        mosi_pad = b;
        #120;
        if (chk) check("miso", 32'(miso_pad), 32'(exp_b));
        sck_pad = 1'b1;
        #120;
        sck_pad = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic [7:0] exp_tx, input bit chk);
        for (int i = 7; i >= 0; i--) sck_bit(b[i], exp_tx[i], chk);
    endtask

    task automatic run_vec(input vec_t v);
        int         b_dreq;
        int         b_dvld;
        logic [7:0] dd [3];
        dd[0] = v.d0;
        dd[1] = v.d1;
        dd[2] = v.d2;
        resp_byte = v.tx;
        b_dreq = n_dreq;
        b_dvld = n_dvld;
        addr_q.push_back(v.addr);
        vr_q.push_back(v.exp_vr);
        csn_pad = 1'b0;
        #160;
        send_byte(v.addr, 8'h00, 1'b0);
        for (int k = 0; k < int'(v.ndata); k++) begin
            data_q.push_back(dd[k]);
`ifdef SPI_ADDR_AUTOINC_EN
            if (k > 0) begin
                addr_q.push_back(v.addr + 8'(k));
                vr_q.push_back(v.exp_vr);
            end
`endif
            send_byte(dd[k], v.tx, 1'b1);
        end
        #160;
        check("valid_read_in_frame", 32'(valid_read), 32'(v.exp_vr));
        check("addr_end_of_frame", 32'(spi_address_rx), 32'(v.exp_addr));
        check("dreq_count", 32'(n_dreq - b_dreq), 32'(v.exp_dreq));
        check("data_pulse_count", 32'(n_dvld - b_dvld), 32'(v.ndata));
        check("addr_q_drained", 32'(addr_q.size()), 32'd0);
        check("data_q_drained", 32'(data_q.size()), 32'd0);
        csn_pad = 1'b1;
        #160;
        check("valid_read_after_csn", 32'(valid_read), 32'd0);
        check("miso_csn_high", 32'(miso_pad), 32'd0);
    endtask

    initial begin
        int b_avld;
        int b_dvld;
`ifdef SPI_ADDR_AUTOINC_EN
        vecs[0] = '{8'h4A, 8'hEF, 8'hFF, 8'hFF, 3'd3, 8'h3C, 1'b0, 4'd5, 8'h4C};
        vecs[2] = '{8'h10, 8'h01, 8'h02, 8'h03, 3'd3, 8'h5A, 1'b0, 4'd5, 8'h12};
        vecs[3] = '{8'hFF, 8'h80, 8'h7F, 8'h00, 3'd2, 8'hC3, 1'b1, 4'd4, 8'h00};
`else
        vecs[0] = '{8'h4A, 8'hEF, 8'hFF, 8'hFF, 3'd3, 8'h3C, 1'b0, 4'd5, 8'h4A};
        vecs[2] = '{8'h10, 8'h01, 8'h02, 8'h03, 3'd3, 8'h5A, 1'b0, 4'd5, 8'h10};
        vecs[3] = '{8'hFF, 8'h80, 8'h7F, 8'h00, 3'd2, 8'hC3, 1'b1, 4'd4, 8'hFF};
`endif
        vecs[1] = '{8'hC1, 8'h3C, 8'h00, 8'h00, 3'd1, 8'hA5, 1'b1, 4'd3, 8'hC1};
        vecs[4] = '{8'h12, 8'h00, 8'h00, 8'h00, 3'd0, 8'h00, 1'b0, 4'd2, 8'h12};
        vecs[5] = '{8'h33, 8'h00, 8'h00, 8'h00, 3'd0, 8'h00, 1'b0, 4'd2, 8'h33};

        fork
            monitor();
            responder();
        join_none

        @(posedge sys_clk);
        #5;
        #100;
        rst = 1'b0;
        #40;
        check("rst_addr", 32'(spi_address_rx), 32'd0);
        check("rst_data", 32'(spi_data_byte_rx), 32'd0);
        check("rst_addr_vld", 32'(spi_address_rx_valid), 32'd0);
        check("rst_data_vld", 32'(spi_data_byte_rx_valid), 32'd0);
        check("rst_dreq", 32'(spi_dreq), 32'd0);
        check("rst_valid_read", 32'(valid_read), 32'd0);
        check("rst_miso", 32'(miso_pad), 32'd0);

        for (int i = 0; i < 4; i++) run_vec(vecs[i]);

        // Abort after 5 bits: no pulses, held outputs, then a clean frame.
        b_avld = n_avld;
        b_dvld = n_dvld;
        csn_pad = 1'b0;
        #160;
        for (int i = 0; i < 5; i++) sck_bit(1'b1, 1'b0, 1'b0);
        csn_pad = 1'b1;
        #160;
        check("abort_addr_pulses", 32'(n_avld - b_avld), 32'd0);
        check("abort_data_pulses", 32'(n_dvld - b_dvld), 32'd0);
        check("abort_addr_held", 32'(spi_address_rx), 32'(vecs[3].exp_addr));
        check("abort_data_held", 32'(spi_data_byte_rx), 32'(vecs[3].d1));
        check("abort_valid_read", 32'(valid_read), 32'd0);
        run_vec(vecs[4]);

        // Reset mid-frame with CSN held low: traffic ignored until CSN toggles.
        csn_pad = 1'b0;
        #160;
        for (int i = 0; i < 3; i++) sck_bit(1'b1, 1'b0, 1'b0);
        rst = 1'b1;
        #60;
        rst = 1'b0;
        #40;
        check("midrst_addr", 32'(spi_address_rx), 32'd0);
        check("midrst_data", 32'(spi_data_byte_rx), 32'd0);
        check("midrst_valid_read", 32'(valid_read), 32'd0);
        check("midrst_miso", 32'(miso_pad), 32'd0);
        b_avld = n_avld;
        b_dvld = n_dvld;
        send_byte(8'h77, 8'h00, 1'b0);
        send_byte(8'h81, 8'h00, 1'b0);
        #160;
        check("midrst_ignored_addr", 32'(n_avld - b_avld), 32'd0);
        check("midrst_ignored_data", 32'(n_dvld - b_dvld), 32'd0);
        check("midrst_miso_ignored", 32'(miso_pad), 32'd0);
        csn_pad = 1'b1;
        #160;
        run_vec(vecs[5]);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
